// File: rtl/rom_loader.sv
// rom_loader: streams a length-prefixed byte image into a ROM array and holds the core in reset until it is loaded.
// Optional checksum byte after the payload is enabled by defining ROM_LOADER_CHECKSUM_EN.
package Constants;
  localparam int ROM_SIZE = 16;
  localparam int BYTE = 8;
endpackage

module rom_loader #(
  parameter int ROM_SIZE = Constants::ROM_SIZE
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      in_valid,
  input  logic [Constants::BYTE-1:0] in_data,
  output logic                      in_ready,
  output logic [Constants::BYTE-1:0] rom [0:ROM_SIZE-1],
  output logic                      cpu_nrst,
  output logic                      done,
  output logic                      error
);
  localparam int AW = $clog2(ROM_SIZE + 1) < 2 ? 2 : $clog2(ROM_SIZE + 1);
  localparam int IW = ROM_SIZE > 1 ? $clog2(ROM_SIZE) : 1;
`ifdef ROM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LEN, DATA, CHK, DONE, ERR} state_t;
  localparam state_t AFTER = CHK;
`else
  typedef enum logic [2:0] {LEN, DATA, DONE, ERR} state_t;
  localparam state_t AFTER = DONE;
`endif
  state_t state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [7:0] rom_q [0:ROM_SIZE-1];
  logic [7:0] rom_d [0:ROM_SIZE-1];
  logic done_q, done_d, error_q, error_d, cpu_nrst_q, cpu_nrst_d;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif
  logic xfer;
  logic [31:0] hdr;

  assign in_ready = state_q != DONE && state_q != ERR;
  assign xfer = in_valid & in_ready;
  assign hdr = {len_q[23:0], in_data};
  assign rom = rom_q;
  assign done = done_q;
  assign error = error_q;
  assign cpu_nrst = cpu_nrst_q;

  // Next-state: header shift-in, payload write at the byte counter, optional checksum compare.
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    cnt_d = cnt_q;
    rom_d = rom_q;
`ifdef ROM_LOADER_CHECKSUM_EN
    sum_d = sum_q;
`endif
    if (xfer) begin
      if (state_q == LEN) begin
        len_d = hdr;
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(3)) begin
          cnt_d = '0;
          state_d = hdr > 32'(ROM_SIZE) ? ERR : hdr == '0 ? AFTER : DATA;
        end
      end else if (state_q == DATA) begin
        rom_d[cnt_q[IW-1:0]] = in_data;
        cnt_d = cnt_q + AW'(1);
`ifdef ROM_LOADER_CHECKSUM_EN
        sum_d = sum_q + in_data;
`endif
        if (32'(cnt_q) == len_q - 32'd1) state_d = AFTER;
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      else if (state_q == CHK) state_d = in_data == sum_q ? DONE : ERR;
`endif
    end
    done_d = state_d == DONE;
    cpu_nrst_d = state_d == DONE;
    error_d = state_d == ERR;
  end

  // State, image and status flops; asynchronous reset discards any partial image.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= LEN;
      len_q <= '0;
      cnt_q <= '0;
      rom_q <= '{default: '0};
      done_q <= 1'b0;
      error_q <= 1'b0;
      cpu_nrst_q <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      rom_q <= rom_d;
      done_q <= done_d;
      error_q <= error_d;
      cpu_nrst_q <= cpu_nrst_d;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum_q <= sum_d;
`endif
    end
  end
endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 The block SHALL have parameter ROM_SIZE, default Constants::ROM_SIZE: number of bytes in the instruction ROM image.
REQ-002 The block SHALL have port clk, input, 1: clock, all state updates on rising edge.
REQ-003 The block SHALL have port nrst, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1: upstream byte valid.
REQ-005 The block SHALL have port in_data, input, 8 (Constants::BYTE): upstream byte.
REQ-006 The block SHALL have port in_ready, output, 1: loader accepts in_data.
REQ-007 The block SHALL have port rom, output, unpacked array [0:ROM_SIZE-1] of 8-bit bytes: image consumed by the fetch stage, byte i at rom[i].
REQ-008 The block SHALL have port cpu_nrst, output, 1: active-low core reset, held low until the image is loaded.
REQ-009 The block SHALL have port done, output, 1: image loaded successfully.
REQ-010 The block SHALL have port error, output, 1: load aborted.

Function
REQ-011 A byte SHALL transfer only on a rising clk edge where in_valid=1 and in_ready=1; in_data is ignored otherwise.
REQ-012 States SHALL be LEN, DATA, CHK, DONE, ERR; state after reset is LEN.
REQ-013 in_ready SHALL be 1 in LEN, DATA, CHK and 0 in DONE, ERR, derived combinationally from state only (no dependency on in_valid).
REQ-014 In LEN, four transfers SHALL form a 32-bit length, big-endian (first byte = bits 31:24), matching fetch byte order.
REQ-015 On the fourth LEN transfer: length > ROM_SIZE SHALL go to ERR; length = 0 SHALL go to CHK if checksum enabled, else DONE; otherwise DATA.
REQ-016 In DATA, the k-th transfer (k from 0) SHALL write in_data to rom[k] on that edge; after transfer k = length-1 the next state SHALL be CHK (checksum enabled) or DONE.
REQ-017 The byte address counter SHALL be wide enough for ROM_SIZE without wrap; writes SHALL never exceed rom[length-1].
REQ-018 rom bytes not written by the payload SHALL keep their reset value 0.
REQ-019 done SHALL be 1 exactly in DONE; error exactly in ERR; cpu_nrst SHALL be 1 exactly in DONE; all three registered (state-decoded from flops, glitch-free).
REQ-020 done/cpu_nrst SHALL rise on the same edge that completes the final transfer (visible the following cycle).
REQ-021 DONE and ERR SHALL be terminal; only nrst leaves them.
REQ-022 in_valid held while in_ready=0 SHALL have no effect.
REQ-023 Idle gaps (in_valid=0) of any length between transfers SHALL not alter state or counters.

Reset
REQ-024 nrst low SHALL asynchronously force: state LEN, length 0, byte counter 0, checksum accumulator 0, all rom bytes 0, cpu_nrst 0, done 0, error 0.
REQ-025 Reset asserted mid-load SHALL discard the partial image; loading restarts with a new length header after release.
REQ-026 in_ready SHALL be 1 in the first cycle after nrst release.

Configuration
REQ-027 Macro ROM_LOADER_CHECKSUM_EN SHALL enable checksum checking.
REQ-028 With ROM_LOADER_CHECKSUM_EN defined: an 8-bit accumulator sums payload bytes mod 256; CHK accepts one byte; equal to accumulator -> DONE, else -> ERR.
REQ-029 Without ROM_LOADER_CHECKSUM_EN: CHK and the accumulator SHALL not exist; DATA (or LEN when length = 0) goes directly to DONE; no trailing byte is consumed.

Verification
REQ-030 Stream 00 00 00 04, 3C 08 00 01, (checksum on: 45) -> rom[0..3]=3C 08 00 01, rom[4..]=00, done=1, cpu_nrst=1, error=0, in_ready=0.
REQ-031 Header length ROM_SIZE+1 -> error=1 after fourth header byte, no rom writes, cpu_nrst=0, in_ready=0.
REQ-032 Checksum on, payload AA 55, checksum byte 00 -> error=1, done=0; checksum byte FF -> done=1.
REQ-033 Length 00 00 00 00 -> done=1 after header (checksum off) or after checksum byte 00 (checksum on); all rom bytes 0.
REQ-034 Length 8, nrst pulsed after 3 payload bytes -> rom all 0, state LEN; fresh 2-byte image then loads correctly.
REQ-035 Random in_valid gaps and in_valid held during DONE -> image identical to gap-free load; no writes after DONE.
